rs232out_arb: RTL and testbench

Two-requester transmit scheduler in front of the RS-232 serial transmitter. It accepts bytes from two independent masters (for example, the CPU peripheral path and a debug monitor), arbitrates between them round-robin, and buffers them in a shared FIFO. It then drains the FIFO into the transmitter one byte at a time, honouring `rs232out_busy`. It sits between the masters and the transmitter's `rs232out_w`/`rs232out_d` inputs, replacing direct writes.

---
 rtl/rs232out_arb.sv | 116 +++++++++++
 tb/tb_rs232out_arb.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232out_arb.sv
// Two-requester round-robin transmit scheduler: arbitrates byte writes into a
// shared FIFO and drains it into the RS-232 transmitter one strobe at a time.
module rs232out_arb #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_w,
  input  logic [7:0]            req0_d,
  output logic                  req0_rdy,
  input  logic                  req1_w,
  input  logic [7:0]            req1_d,
  output logic                  req1_rdy,
  input  logic                  rs232out_busy,
  output logic                  rs232out_w,
  output logic [7:0]            rs232out_d,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SETTLE = 1'b1
  } state_t;

  state_t                r_state;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [LW-1:0]         r_level;
  logic                  r_last;
  logic                  r_strobe;
  logic [7:0]            r_data;

  logic                  w_full;
  logic                  w_push0;
  logic                  w_push1;
  logic                  w_push;
  logic                  w_pop;
  logic [7:0]            w_din;

  // Ready is a pure function of registered state and the competing request;
  // the two pushes are mutually exclusive because they need opposite r_last.
  assign w_full   = (r_level == LW'(DEPTH));
  assign req0_rdy = !w_full && (!req1_w || r_last);
  assign req1_rdy = !w_full && (!req0_w || !r_last);
  assign w_push0  = req0_w && req0_rdy;
  assign w_push1  = req1_w && req1_rdy;
  assign w_push   = w_push0 || w_push1;
  assign w_din    = w_push1 ? req1_d : req0_d;

  assign w_pop    = (r_state == S_IDLE) && (r_level != '0) && !rs232out_busy;

  assign rs232out_w = r_strobe;
  assign rs232out_d = r_data;
  assign level      = r_level;

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_din;
    end
  end

  // Pointers, occupancy and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_last  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + DEPTH_LOG2'(1);
        r_last <= w_push1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + DEPTH_LOG2'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Drain FSM: one strobe, then a settle cycle while the transmitter raises busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_strobe <= 1'b0;
      r_data   <= 8'h00;
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_strobe <= 1'b1;
            r_data   <= r_mem[r_rptr];
            r_state  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232out_arb.sv
// Directed bench for rs232out_arb: arbitration, backpressure, busy handshake,
// pointer wrap with random busy, and mid-stream reset.
module tb_rs232out_arb;

  logic       clk;
  logic       rst;
  logic       req0_w;
  logic [7:0] req0_d;
  logic       req0_rdy;
  logic       req1_w;
  logic [7:0] req1_d;
  logic       req1_rdy;
  logic       rs232out_busy;
  logic       rs232out_w;
  logic [7:0] rs232out_d;
  logic [4:0] level;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ref_level = 0;
  int busy_viol = 0;
  int busy_mode = 0;   // 0 manual, 1 transmitter model, 2 random
  int busy_cnt = 0;
  logic [7:0] out_q[$];
  int         strobe_cyc[$];

  rs232out_arb #(.DEPTH_LOG2(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req0_w        (req0_w),
    .req0_d        (req0_d),
    .req0_rdy      (req0_rdy),
    .req1_w        (req1_w),
    .req1_d        (req1_d),
    .req1_rdy      (req1_rdy),
    .rs232out_busy (rs232out_busy),
    .rs232out_w    (rs232out_w),
    .rs232out_d    (rs232out_d),
    .level         (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: inputs were set at the previous negedge; observe at the next negedge.
  task automatic step();
    logic push;
    logic bz;
    logic r;
    #1;
    push = (req0_w && req0_rdy) || (req1_w && req1_rdy);
    bz   = rs232out_busy;
    r    = rst;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (r) begin
      ref_level = 0;
    end else begin
      if (push)       ref_level++;
      if (rs232out_w) ref_level--;
    end
    if (rs232out_w) begin
      out_q.push_back(rs232out_d);
      strobe_cyc.push_back(cyc);
      if (bz) busy_viol++;
    end
    if (busy_mode == 1) begin
      if (rs232out_w)        busy_cnt = 10;
      else if (busy_cnt > 0) busy_cnt--;
      rs232out_busy = (busy_cnt != 0);
    end else if (busy_mode == 2) begin
      rs232out_busy = ($urandom_range(0, 1) == 1);
    end
  endtask

  task automatic do_reset();
    req0_w = 1'b0;
    req1_w = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_q.delete();
    strobe_cyc.delete();
    busy_cnt = 0;
    busy_viol = 0;
  endtask

  initial begin
    int n;
    int i0;
    int i1;
    logic [7:0] exp_tie [8];
    rst = 1'b1;
    req0_w = 1'b0;
    req0_d = 8'h00;
    req1_w = 1'b0;
    req1_d = 8'h00;
    rs232out_busy = 1'b0;
    @(negedge clk);
    do_reset();
    step();

    // Reset state
    #1;
    check("rst_w", 32'(rs232out_w), 32'd0);
    check("rst_d", 32'(rs232out_d), 32'h00);
    check("rst_level", 32'(level), 32'd0);
    check("rst_rdy0", 32'(req0_rdy), 32'd1);
    check("rst_rdy1", 32'(req1_rdy), 32'd1);

    // Single byte
    @(negedge clk);
    req0_w = 1'b1;
    req0_d = 8'h41;
    #1;
    check("single_rdy0", 32'(req0_rdy), 32'd1);
    step();
    req0_w = 1'b0;
    check("single_level1", 32'(level), 32'd1);
    check("single_w_early", 32'(rs232out_w), 32'd0);
    step();
    check("single_w", 32'(rs232out_w), 32'd1);
    check("single_d", 32'(rs232out_d), 32'h41);
    check("single_level0", 32'(level), 32'd0);
    step();
    check("single_w_drop", 32'(rs232out_w), 32'd0);
    check("single_d_hold", 32'(rs232out_d), 32'h41);
    step();
    check("single_count", 32'(out_q.size()), 32'd1);

    // Tie arbitration
    do_reset();
    exp_tie = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3};
    n = 0; i0 = 0; i1 = 0;
    for (int t = 0; t < 30 && n < 8; t++) begin
      req0_w = (i0 < 4);
      req0_d = 8'hA0 + 8'(i0);
      req1_w = (i1 < 4);
      req1_d = 8'hB0 + 8'(i1);
      #1;
      check($sformatf("tie_rdy0_%0d", n), 32'(req0_rdy), 32'((n % 2) == 0));
      check($sformatf("tie_rdy1_%0d", n), 32'(req1_rdy), 32'((n % 2) == 1));
      if (req0_w && req0_rdy) begin i0++; n++; end
      else if (req1_w && req1_rdy) begin i1++; n++; end
      step();
    end
    req0_w = 1'b0;
    req1_w = 1'b0;
    check("tie_accepts", 32'(n), 32'd8);
    for (int t = 0; t < 40 && out_q.size() < 8; t++) step();
    check("tie_count", 32'(out_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < out_q.size(); k++)
      check($sformatf("tie_order_%0d", k), 32'(out_q[k]), 32'(exp_tie[k]));

    // Backpressure
    do_reset();
    rs232out_busy = 1'b1;
    for (int k = 0; k < 16; k++) begin
      req0_w = 1'b1;
      req0_d = 8'h60 + 8'(k);
      #1;
      check($sformatf("bp_rdy_%0d", k), 32'(req0_rdy), 32'd1);
      step();
    end
    check("bp_level16", 32'(level), 32'd16);
    req0_d = 8'h70;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_full_rdy_%0d", k), 32'(req0_rdy), 32'd0);
      step();
      check($sformatf("bp_full_level_%0d", k), 32'(level), 32'd16);
    end
    check("bp_no_strobe_busy", 32'(out_q.size()), 32'd0);
    rs232out_busy = 1'b0;
    begin
      logic acc;
      acc = 1'b0;
      for (int t = 0; t < 10 && !acc; t++) begin
        #1;
        acc = req0_rdy;
        step();
      end
      check("bp_17th_accepted", 32'(acc), 32'd1);
    end
    req0_w = 1'b0;
    for (int t = 0; t < 80 && out_q.size() < 17; t++) step();
    check("bp_count", 32'(out_q.size()), 32'd17);
    for (int k = 0; k < 17 && k < out_q.size(); k++)
      check($sformatf("bp_order_%0d", k), 32'(out_q[k]), 32'(8'h60 + 8'(k)));
    check("bp_level_empty", 32'(level), 32'd0);
    check("bp_busy_viol", 32'(busy_viol), 32'd0);

    // Busy handshake
    do_reset();
    busy_mode = 1;
    rs232out_busy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req0_w = 1'b1;
      req0_d = 8'hC0 + 8'(k);
      step();
    end
    req0_w = 1'b0;
    for (int t = 0; t < 80 && strobe_cyc.size() < 3; t++) step();
    check("hs_count", 32'(strobe_cyc.size()), 32'd3);
    if (strobe_cyc.size() >= 3) begin
      check("hs_gap1", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd11);
      check("hs_gap2", 32'(strobe_cyc[2] - strobe_cyc[1]), 32'd11);
      for (int k = 0; k < 3; k++)
        check($sformatf("hs_order_%0d", k), 32'(out_q[k]), 32'(8'hC0 + 8'(k)));
    end
    check("hs_busy_viol", 32'(busy_viol), 32'd0);
    for (int t = 0; t < 12; t++) step();
    busy_mode = 0;
    rs232out_busy = 1'b0;

    // Wrap and simultaneous push/pop with random busy
    do_reset();
    busy_mode = 2;
    i0 = 0;
    for (int t = 0; t < 600 && out_q.size() < 40; t++) begin
      req0_w = (i0 < 40);
      req0_d = 8'(i0);
      #1;
      check($sformatf("wrap_rdy_c%0d", t), 32'(req0_rdy), 32'(ref_level != 16));
      if (req0_w && req0_rdy) i0++;
      step();
      check($sformatf("wrap_level_c%0d", t), 32'(level), 32'(ref_level));
    end
    req0_w = 1'b0;
    check("wrap_count", 32'(out_q.size()), 32'd40);
    for (int k = 0; k < 40 && k < out_q.size(); k++)
      check($sformatf("wrap_order_%0d", k), 32'(out_q[k]), 32'(k));
    check("wrap_busy_viol", 32'(busy_viol), 32'd0);
    busy_mode = 0;
    rs232out_busy = 1'b0;

    // Reset mid-stream
    do_reset();
    rs232out_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      req0_w = 1'b1;
      req0_d = 8'h80 + 8'(k);
      step();
    end
    req0_w = 1'b0;
    check("mr_level5", 32'(level), 32'd5);
    rst = 1'b1;
    rs232out_busy = 1'b0;
    step();
    rst = 1'b0;
    check("mr_level0", 32'(level), 32'd0);
    check("mr_no_strobe", 32'(rs232out_w), 32'd0);
    step();
    check("mr_no_strobe2", 32'(rs232out_w), 32'd0);
    out_q.delete();
    req0_w = 1'b1;
    req0_d = 8'h99;
    step();
    req0_w = 1'b0;
    for (int t = 0; t < 10 && out_q.size() < 1; t++) step();
    for (int t = 0; t < 4; t++) step();
    check("mr_count", 32'(out_q.size()), 32'd1);
    if (out_q.size() > 0) check("mr_first", 32'(out_q[0]), 32'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
